// File: rtl/prism_sp_pkg.sv
// Shared stream-processor types: GEM RX descriptor layout, acquire cookie and walker state encoding.
package prism_sp_pkg;

   localparam int unsigned ADDR_W  = 40;
   localparam int unsigned RDATA_W = 128;
   localparam int unsigned DESC_W  = 96;

   localparam bit DMA_DESC_64BITADDR = 1'b0;

   localparam int unsigned GEM_RX_DESC_USED_BIT = 0;
   localparam int unsigned GEM_RX_DESC_WRAP_BIT = 1;

   // w0 occupies the least significant bits so a raw read beat casts directly.
   typedef struct packed {
      logic [31:0] w2;
      logic [31:0] w1;
      logic [31:0] w0;
   } gem_dma_rx_desc_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [ADDR_W-1:0] data_addr;
      logic              wrap;
   } dma_rx_cookie_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_CHECK,
      ST_EMIT,
      ST_BACKOFF
   } walk_state_e;

endpackage

// File: rtl/prism_sp_ring_acquire_cookie_convert_interface.sv
// Hookup between a captured RX descriptor and the descriptor-to-cookie converter.
interface prism_sp_ring_acquire_cookie_convert_interface;
   import prism_sp_pkg::*;

   gem_dma_rx_desc_t  desc;
   logic [ADDR_W-1:0] desc_addr;
   dma_rx_cookie_t    cookie;
   logic              used;

   modport src (output desc, desc_addr, input cookie, used);
   modport cvt (input desc, desc_addr, output cookie, used);

endinterface

// File: rtl/prism_sp_rx_desc_ring_walker_if.sv
// Descriptor read port and cookie output handshake of the RX ring walker.
interface prism_sp_rx_desc_ring_walker_if;
   import prism_sp_pkg::*;

   logic                rd_req;
   logic [ADDR_W-1:0]   rd_addr;
   logic                rd_gnt;
   logic                rd_rvalid;
   logic [RDATA_W-1:0]  rd_rdata;
   logic                cookie_valid;
   logic                cookie_ready;
   dma_rx_cookie_t      cookie;

   modport master (
      output rd_req, rd_addr, cookie_valid, cookie,
      input  rd_gnt, rd_rvalid, rd_rdata, cookie_ready
   );

   modport slave (
      input  rd_req, rd_addr, cookie_valid, cookie,
      output rd_gnt, rd_rvalid, rd_rdata, cookie_ready
   );

endinterface

// File: rtl/prism_sp_rx_desc_ring_walker_cvt.sv
// Combinational GEM RX descriptor to acquire-cookie converter.
module prism_sp_rx_desc_ring_walker_cvt #(
   parameter bit DMA_DESC_64BITADDR = prism_sp_pkg::DMA_DESC_64BITADDR
) (
   prism_sp_ring_acquire_cookie_convert_interface.cvt cv
);
   import prism_sp_pkg::*;

   logic [7:0] addrh;
   logic       unused_bits;

   // 8-byte descriptors carry no high address byte.
   assign addrh = DMA_DESC_64BITADDR ? cv.desc.w2[7:0] : 8'h00;

   assign cv.used   = cv.desc.w0[GEM_RX_DESC_USED_BIT];
   assign cv.cookie = '{addr:      cv.desc_addr,
                        data_addr: {addrh, cv.desc.w0[31:2], 2'b00},
                        wrap:      cv.desc.w0[GEM_RX_DESC_WRAP_BIT]};

   assign unused_bits = ^{cv.desc.w1, cv.desc.w2};

endmodule

// File: rtl/prism_sp_rx_desc_ring_walker.sv
// Walks the GEM RX descriptor ring, polls not-yet-released entries and emits acquire cookies.
module prism_sp_rx_desc_ring_walker
   import prism_sp_pkg::ADDR_W;
#(
   parameter bit          DMA_DESC_64BITADDR = prism_sp_pkg::DMA_DESC_64BITADDR,
   parameter int unsigned POLL_W             = 16
) (
   input  logic                           clock,
   input  logic                           resetn,
   input  logic                           enable_i,
   input  logic [ADDR_W-1:0]              ring_base_i,
   input  logic [POLL_W-1:0]              poll_interval_i,
   prism_sp_rx_desc_ring_walker_if.master bus,
   output logic [ADDR_W-1:0]              desc_cur_o,
   output logic                           busy_o
);
   import prism_sp_pkg::*;

   localparam logic [ADDR_W-1:0] DESC_STRIDE = DMA_DESC_64BITADDR ? ADDR_W'(16) : ADDR_W'(8);

   walk_state_e       state_q, state_d;
   logic [ADDR_W-1:0] desc_cur_q, desc_cur_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [POLL_W-1:0] poll_q, poll_d;
   logic [ADDR_W-1:0] rd_addr_q;
   logic              rd_req_q, cookie_valid_q, busy_q;
   gem_dma_rx_desc_t  desc_q;
   dma_rx_cookie_t    cookie_q;
   logic              unused_rdata;

   prism_sp_ring_acquire_cookie_convert_interface cv_if ();

   assign cv_if.desc      = desc_q;
   assign cv_if.desc_addr = desc_cur_q;

   prism_sp_rx_desc_ring_walker_cvt #(
      .DMA_DESC_64BITADDR(DMA_DESC_64BITADDR)
   ) u_cvt (
      .cv(cv_if.cvt)
   );

   // Next-state, poll counter and ring pointer.
   always_comb begin
      state_d    = state_q;
      desc_cur_d = desc_cur_q;
      base_d     = base_q;
      poll_d     = poll_q;
      unique case (state_q)
         ST_IDLE: begin
            if (enable_i) begin
               state_d    = ST_REQ;
               base_d     = ring_base_i;
               desc_cur_d = ring_base_i;
            end
         end
         ST_REQ: begin
            if (bus.rd_gnt)     state_d = ST_WAIT;
            else if (!enable_i) state_d = ST_IDLE;
         end
         ST_WAIT: begin
            // The read always completes; its data is dropped if the walker was disabled.
            if (bus.rd_rvalid) state_d = enable_i ? ST_CHECK : ST_IDLE;
         end
         ST_CHECK: begin
            if (cv_if.used) begin
               state_d = ST_BACKOFF;
               poll_d  = poll_interval_i;
            end else begin
               state_d = ST_EMIT;
            end
         end
         ST_BACKOFF: begin
            if (!enable_i)          state_d = ST_IDLE;
            else if (poll_q == '0)  state_d = ST_REQ;
            else                    poll_d  = poll_q - POLL_W'(1);
         end
         ST_EMIT: begin
            if (bus.cookie_ready) begin
               desc_cur_d = cookie_q.wrap ? base_q : desc_cur_q + DESC_STRIDE;
               state_d    = enable_i ? ST_REQ : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Registered state and outputs derived from the upcoming state.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q        <= ST_IDLE;
         desc_cur_q     <= '0;
         base_q         <= '0;
         poll_q         <= '0;
         rd_addr_q      <= '0;
         rd_req_q       <= 1'b0;
         cookie_valid_q <= 1'b0;
         busy_q         <= 1'b0;
         desc_q         <= '0;
         cookie_q       <= '0;
      end else begin
         state_q        <= state_d;
         desc_cur_q     <= desc_cur_d;
         base_q         <= base_d;
         poll_q         <= poll_d;
         rd_req_q       <= (state_d == ST_REQ);
         cookie_valid_q <= (state_d == ST_EMIT);
         busy_q         <= (state_d != ST_IDLE);
         if (state_d == ST_REQ) rd_addr_q <= desc_cur_d;
         if (state_q == ST_WAIT && bus.rd_rvalid) desc_q <= gem_dma_rx_desc_t'(bus.rd_rdata[DESC_W-1:0]);
         if (state_q == ST_CHECK && state_d == ST_EMIT) cookie_q <= cv_if.cookie;
      end
   end

   assign bus.rd_req       = rd_req_q;
   assign bus.rd_addr      = rd_addr_q;
   assign bus.cookie_valid = cookie_valid_q;
   assign bus.cookie       = cookie_q;
   assign desc_cur_o       = desc_cur_q;
   assign busy_o           = busy_q;

   assign unused_rdata = ^bus.rd_rdata[RDATA_W-1:DESC_W];

endmodule
